// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the ALU sequencer slice:
//   - decoder opcode values accepted on the instruction channel
//   - opcodes driven to the ALU
//   - branch compare-kind (ltgt) codes
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  // Default geometry
  localparam int REG_AW_DEF = 4;
  localparam int PC_W_DEF   = 8;

  // Instruction opcodes as delivered by the decoder
  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_EPAR   = 4'd5;

  // Opcodes understood by the ALU (add and sub share one, split by alu_eq)
  localparam logic [3:0] ALU_ADDSUB = 4'd0;
  localparam logic [3:0] ALU_BRANCH = 4'd4;
  localparam logic [3:0] ALU_EPAR   = 4'd5;

  // Branch compare kinds; with alu_eq=1 the inclusive/equal variant is used
  localparam logic [2:0] LTGT_EQ = 3'd0;  // eq / ne
  localparam logic [2:0] LTGT_LE = 3'd1;  // le / lt
  localparam logic [2:0] LTGT_GE = 3'd2;  // ge / gt

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
//   Decoded-instruction channel from the decoder to the sequencer.
//   valid/ready handshake; fields are taken in the cycle valid && ready.
//   Signals: valid, ready, op[3:0], eq, ltgt[2:0], rd, rs, target.
//   master: decoder side.  slave: sequencer side.
// -----------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int REG_AW = 4,
  parameter int PC_W   = 8
);
  logic              valid;
  logic              ready;
  logic [3:0]        op;
  logic              eq;
  logic [2:0]        ltgt;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [PC_W-1:0]   target;

  modport master (output valid, op, eq, ltgt, rd, rs, target, input  ready);
  modport slave  (input  valid, op, eq, ltgt, rd, rs, target, output ready);
endinterface

// File: rtl/alu_seq_decode.sv
// -----------------------------------------------------------------------------
// alu_seq_decode
//   Combinational decode of the latched instruction fields.
//   Ports:
//     op[3:0], eq, ltgt[2:0]  in   latched opcode and branch compare fields
//     legal                   out  instruction may execute
//     is_branch               out  opcode is a branch
//     alu_op[3:0]             out  opcode to present to the ALU
//     alu_eq                  out  ALU eq select (add=1, sub=0, branch=eq)
// -----------------------------------------------------------------------------
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic       eq,
  input  logic [2:0] ltgt,
  output logic       legal,
  output logic       is_branch,
  output logic [3:0] alu_op,
  output logic       alu_eq
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    legal     = 1'b0;
    is_branch = 1'b0;
    alu_op    = ALU_ADDSUB;
    alu_eq    = 1'b0;
    case (op)
      OP_ADD: begin
        legal  = 1'b1;
        alu_eq = 1'b1;
      end
      OP_SUB: begin
        legal  = 1'b1;
      end
      OP_EPAR: begin
        legal  = 1'b1;
        alu_op = ALU_EPAR;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        legal     = (ltgt <= LTGT_GE);
        alu_op    = ALU_BRANCH;
        alu_eq    = eq;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Multi-cycle controller running one instruction at a time through
//   IDLE -> READ -> EXEC -> WB -> IDLE. Accept at cycle T, READ at T+1,
//   EXEC (ALU enabled) at T+2, write-back / PC load at T+3, ready at T+4.
//   Illegal instructions return from READ to IDLE with a one-cycle
//   'illegal' pulse.
//
//   Ports:
//     clock, reset            rising-edge clock, synchronous active-high reset
//     instr                   alu_seq_if.slave instruction channel
//     rf_raddr_a/b, rf_rdata_a/b   register-file reads (data sampled at end of READ)
//     rf_we, rf_waddr, rf_wdata    register-file write, one-cycle pulse in WB
//     alu_res, alu_register   ALU operands A/B, non-zero in EXEC only
//     alu_op, alu_format, alu_eq, alu_ltgt   ALU control (alu_format = enable)
//     alu_out, alu_compres    ALU result / compare result, sampled at end of EXEC
//     pc_load, pc_target      taken-branch pulse in WB with its target
//     illegal                 one-cycle pulse on a rejected instruction
//
//   Optional build macro ALU_SEQ_STATS_EN adds stat_retired[15:0] (legal
//   instructions completing WB) and stat_taken[15:0] (pc_load pulses).
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  alu_seq_if.slave          instr,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [15:0]       rf_rdata_a,
  input  logic [15:0]       rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [15:0]       rf_wdata,
  output logic [15:0]       alu_res,
  output logic [15:0]       alu_register,
  output logic [3:0]        alu_op,
  output logic              alu_format,
  output logic              alu_eq,
  output logic [2:0]        alu_ltgt,
  input  logic [15:0]       alu_out,
  input  logic              alu_compres,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              illegal
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_retired,
  output logic [15:0]       stat_taken
`endif
);

  state_e            state;
  logic              ready_q;
  logic              rf_we_q;
  logic              pc_load_q;

  // Instruction fields latched at accept
  logic [3:0]        op_q;
  logic              eq_q;
  logic [2:0]        ltgt_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs_q;
  logic [PC_W-1:0]   target_q;

  logic              dec_legal;
  logic              dec_branch;
  logic [3:0]        dec_alu_op;
  logic              dec_alu_eq;

  alu_seq_decode u_decode (
    .op        (op_q),
    .eq        (eq_q),
    .ltgt      (ltgt_q),
    .legal     (dec_legal),
    .is_branch (dec_branch),
    .alu_op    (dec_alu_op),
    .alu_eq    (dec_alu_eq)
  );

  assign instr.ready = ready_q;

  // A reset arriving while a write-back or PC load is on the outputs must
  // suppress it in that same cycle, so the registered pulses are gated.
  assign rf_we   = rf_we_q   & ~reset;
  assign pc_load = pc_load_q & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sequential state is assigned with <= only, so every register
      // here sees the values from before this edge regardless of order.
      state        <= S_IDLE;
      ready_q      <= 1'b1;
      rf_we_q      <= 1'b0;
      pc_load_q    <= 1'b0;
      illegal      <= 1'b0;
      op_q         <= '0;
      eq_q         <= 1'b0;
      ltgt_q       <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      target_q     <= '0;
      rf_raddr_a   <= '0;
      rf_raddr_b   <= '0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      alu_res      <= '0;
      alu_register <= '0;
      alu_op       <= '0;
      alu_format   <= 1'b0;
      alu_eq       <= 1'b0;
      alu_ltgt     <= '0;
      pc_target    <= '0;
`ifdef ALU_SEQ_STATS_EN
      stat_retired <= '0;
      stat_taken   <= '0;
`endif
    end else begin
      // Single-cycle pulses fall back to 0 unless a state re-asserts them
      illegal   <= 1'b0;
      rf_we_q   <= 1'b0;
      pc_load_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (instr.valid && ready_q) begin
            op_q       <= instr.op;
            eq_q       <= instr.eq;
            ltgt_q     <= instr.ltgt;
            rd_q       <= instr.rd;
            rs_q       <= instr.rs;
            target_q   <= instr.target;
            rf_raddr_a <= instr.rd;
            rf_raddr_b <= instr.rs;
            ready_q    <= 1'b0;
            state      <= S_READ;
          end
        end

        S_READ: begin
          rf_raddr_a <= '0;
          rf_raddr_b <= '0;
          if (!dec_legal) begin
            illegal <= 1'b1;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            alu_res      <= rf_rdata_a;
            alu_register <= rf_rdata_b;
            alu_op       <= dec_alu_op;
            alu_eq       <= dec_alu_eq;
            alu_ltgt     <= dec_branch ? ltgt_q : 3'd0;
            alu_format   <= 1'b1;
            state        <= S_EXEC;
          end
        end

        S_EXEC: begin
          alu_res      <= '0;
          alu_register <= '0;
          alu_op       <= '0;
          alu_eq       <= 1'b0;
          alu_ltgt     <= '0;
          alu_format   <= 1'b0;
          if (dec_branch) begin
            pc_load_q <= alu_compres;
            pc_target <= alu_compres ? target_q : '0;
          end else begin
            rf_we_q  <= 1'b1;
            rf_waddr <= rd_q;
            rf_wdata <= alu_out;
          end
          state <= S_WB;
        end

        S_WB: begin
          rf_waddr  <= '0;
          rf_wdata  <= '0;
          pc_target <= '0;
          ready_q   <= 1'b1;
          state     <= S_IDLE;
`ifdef ALU_SEQ_STATS_EN
          stat_retired <= stat_retired + 16'd1;
          if (pc_load_q) stat_taken <= stat_taken + 16'd1;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a behavioural register file
//   (asynchronous read) and a behavioural ALU. Expected write-backs, PC loads
//   and illegal pulses are queued when an instruction is issued and matched
//   as the DUT produces them, together with the cycle they appear in.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int AW = 4;
  localparam int PW = 8;

  localparam int EV_WRITE   = 0;
  localparam int EV_PCLOAD  = 1;
  localparam int EV_ILLEGAL = 2;

  typedef struct {
    int          kind;
    int          cyc;    // cycles after the accept cycle
    logic [15:0] val;
    logic [7:0]  addr;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0]   rf_rdata_a, rf_rdata_b, rf_wdata;
  logic          rf_we;
  logic [15:0]   alu_res, alu_register, alu_out;
  logic [3:0]    alu_op;
  logic          alu_format, alu_eq, alu_compres;
  logic [2:0]    alu_ltgt;
  logic          pc_load;
  logic [PW-1:0] pc_target;
  logic          illegal;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]   stat_retired, stat_taken;
`endif

  logic [15:0] regs [16];
  ev_t         sb [$];
  int          errors = 0;
  int          checks = 0;

  alu_seq_if #(.REG_AW(AW), .PC_W(PW)) ifc ();

  alu_sequencer #(.REG_AW(AW), .PC_W(PW)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr        (ifc),
    .rf_raddr_a   (rf_raddr_a),
    .rf_raddr_b   (rf_raddr_b),
    .rf_rdata_a   (rf_rdata_a),
    .rf_rdata_b   (rf_rdata_b),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .alu_res      (alu_res),
    .alu_register (alu_register),
    .alu_op       (alu_op),
    .alu_format   (alu_format),
    .alu_eq       (alu_eq),
    .alu_ltgt     (alu_ltgt),
    .alu_out      (alu_out),
    .alu_compres  (alu_compres),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .illegal      (illegal)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_retired (stat_retired),
    .stat_taken   (stat_taken)
`endif
  );

  always #5 clock = ~clock;

  // Register file: asynchronous read
  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];

  // Behavioural ALU
  always_comb begin
    alu_out     = 16'h0000;
    alu_compres = 1'b0;
    if (alu_format) begin
      case (alu_op)
        4'd0: alu_out = alu_eq ? (alu_res + alu_register) : (alu_res - alu_register);
        4'd5: alu_out = {15'b0, ^alu_res};
        4'd4: begin
          case (alu_ltgt)
            3'd0: alu_compres = alu_eq ? (alu_res == alu_register) : (alu_res != alu_register);
            3'd1: alu_compres = alu_eq ? (alu_res <= alu_register) : (alu_res <  alu_register);
            3'd2: alu_compres = alu_eq ? (alu_res >= alu_register) : (alu_res >  alu_register);
            default: alu_compres = 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic push_ev(input int kind, input int cyc, input logic [15:0] val, input logic [7:0] addr);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.val  = val;
    e.addr = addr;
    sb.push_back(e);
  endtask

  // Match one DUT event against the head of the scoreboard
  task automatic got_ev(input string tag, input int kind, input int cyc, input logic [15:0] val, input logic [7:0] addr);
    ev_t e;
    if (sb.size() == 0) begin
      e.kind = -1;
      e.cyc  = -1;
      e.val  = 16'hxxxx;
      e.addr = 8'hxx;
    end else begin
      e = sb.pop_front();
    end
    check({tag, "_ev_kind"}, kind, e.kind);
    check({tag, "_ev_cycle"}, cyc, e.cyc);
    check({tag, "_ev_addr"}, {24'b0, addr}, {24'b0, e.addr});
    check({tag, "_ev_data"}, {16'b0, val}, {16'b0, e.val});
  endtask

  // Offer an instruction; returns at the falling edge inside the READ cycle
  task automatic issue(input logic [3:0] op, input logic eq, input logic [2:0] ltgt,
                       input logic [3:0] rd, input logic [3:0] rs, input logic [7:0] tgt);
    int n;
    n = 0;
    @(negedge clock);
    while (!ifc.ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_issue", {31'b0, ifc.ready}, 32'd1);
    ifc.op     = op;
    ifc.eq     = eq;
    ifc.ltgt   = ltgt;
    ifc.rd     = rd;
    ifc.rs     = rs;
    ifc.target = tgt;
    ifc.valid  = 1'b1;
    @(negedge clock);
    ifc.valid  = 1'b0;
  endtask

  // Watch cycles T+1..T+5 after an accept
  task automatic observe(input string tag, input bit legal, input logic [3:0] e_op, input logic e_eq,
                         input logic [2:0] e_ltgt, input logic [15:0] e_a, input logic [15:0] e_b);
    int ready_at;
    ready_at = -1;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge clock);
      if (c == 1) begin
        check({tag, "_raddr_a"}, {28'b0, rf_raddr_a}, {28'b0, ifc.rd});
        check({tag, "_raddr_b"}, {28'b0, rf_raddr_b}, {28'b0, ifc.rs});
        check({tag, "_fmt_read"}, {31'b0, alu_format}, 32'd0);
      end
      if (c == 2 && legal) begin
        check({tag, "_alu_format"}, {31'b0, alu_format}, 32'd1);
        check({tag, "_alu_op"}, {28'b0, alu_op}, {28'b0, e_op});
        check({tag, "_alu_eq"}, {31'b0, alu_eq}, {31'b0, e_eq});
        if (e_op == 4'd4) check({tag, "_alu_ltgt"}, {29'b0, alu_ltgt}, {29'b0, e_ltgt});
        check({tag, "_alu_a"}, {16'b0, alu_res}, {16'b0, e_a});
        check({tag, "_alu_b"}, {16'b0, alu_register}, {16'b0, e_b});
      end
      if (c == 3) begin
        check({tag, "_fmt_after"}, {31'b0, alu_format}, 32'd0);
        check({tag, "_alu_a_after"}, {16'b0, alu_res}, 32'd0);
      end
      if (rf_we)   got_ev(tag, EV_WRITE,   c, rf_wdata, {4'b0, rf_waddr});
      if (pc_load) got_ev(tag, EV_PCLOAD,  c, 16'h0000, pc_target);
      if (illegal) got_ev(tag, EV_ILLEGAL, c, 16'h0000, 8'h00);
      if (ifc.ready && ready_at < 0) ready_at = c;
    end
    check({tag, "_ready_cycle"}, ready_at, legal ? 32'd4 : 32'd2);
    check({tag, "_sb_left"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    ifc.valid  = 1'b0;
    ifc.op     = 4'd0;
    ifc.eq     = 1'b0;
    ifc.ltgt   = 3'd0;
    ifc.rd     = 4'd0;
    ifc.rs     = 4'd0;
    ifc.target = 8'd0;
    reset      = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_ready", {31'b0, ifc.ready}, 32'd1);
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("rst_pc_load", {31'b0, pc_load}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_alu_format", {31'b0, alu_format}, 32'd0);
    check("rst_raddr_a", {28'b0, rf_raddr_a}, 32'd0);
    check("rst_wdata", {16'b0, rf_wdata}, 32'd0);
    check("rst_pc_target", {24'b0, pc_target}, 32'd0);
    reset = 1'b0;

    // add r1=5 + r2=7 -> 12
    regs[1] = 16'd5; regs[2] = 16'd7;
    push_ev(EV_WRITE, 3, 16'd12, 8'd1);
    issue(OP_ADD, 1'b0, 3'd0, 4'd1, 4'd2, 8'd0);
    observe("add", 1'b1, 4'd0, 1'b1, 3'd0, 16'd5, 16'd7);

    // sub r1=3 - r2=5 wraps to 0xFFFE
    regs[1] = 16'd3; regs[2] = 16'd5;
    push_ev(EV_WRITE, 3, 16'hFFFE, 8'd1);
    issue(OP_SUB, 1'b0, 3'd0, 4'd1, 4'd2, 8'd0);
    observe("sub", 1'b1, 4'd0, 1'b0, 3'd0, 16'd3, 16'd5);

    // epar: three set bits -> 1, two set bits -> 0
    regs[3] = 16'h0007; regs[0] = 16'h1234;
    push_ev(EV_WRITE, 3, 16'd1, 8'd3);
    issue(OP_EPAR, 1'b0, 3'd0, 4'd3, 4'd0, 8'd0);
    observe("epar7", 1'b1, 4'd5, 1'b0, 3'd0, 16'h0007, 16'h1234);

    regs[3] = 16'h0003;
    push_ev(EV_WRITE, 3, 16'd0, 8'd3);
    issue(OP_EPAR, 1'b0, 3'd0, 4'd3, 4'd0, 8'd0);
    observe("epar3", 1'b1, 4'd5, 1'b0, 3'd0, 16'h0003, 16'h1234);

    // branch lt: 2 < 9 taken, 9 < 9 not taken
    regs[1] = 16'd2; regs[2] = 16'd9;
    push_ev(EV_PCLOAD, 3, 16'h0000, 8'h40);
    issue(OP_BRANCH, 1'b0, 3'd1, 4'd1, 4'd2, 8'h40);
    observe("br_lt_taken", 1'b1, 4'd4, 1'b0, 3'd1, 16'd2, 16'd9);

    regs[1] = 16'd9;
    issue(OP_BRANCH, 1'b0, 3'd1, 4'd1, 4'd2, 8'h40);
    observe("br_lt_not", 1'b1, 4'd4, 1'b0, 3'd1, 16'd9, 16'd9);

    // Illegal opcode and illegal compare kind
    push_ev(EV_ILLEGAL, 2, 16'h0000, 8'h00);
    issue(4'd7, 1'b0, 3'd0, 4'd1, 4'd2, 8'h00);
    observe("ill_op7", 1'b0, 4'd0, 1'b0, 3'd0, 16'd0, 16'd0);

    push_ev(EV_ILLEGAL, 2, 16'h0000, 8'h00);
    issue(OP_BRANCH, 1'b0, 3'd3, 4'd1, 4'd2, 8'h40);
    observe("ill_ltgt3", 1'b0, 4'd0, 1'b0, 3'd0, 16'd0, 16'd0);

    // rd == rs: both ports read the same register
    regs[4] = 16'h0100;
    push_ev(EV_WRITE, 3, 16'h0200, 8'd4);
    issue(OP_ADD, 1'b0, 3'd0, 4'd4, 4'd4, 8'd0);
    observe("add_same", 1'b1, 4'd0, 1'b1, 3'd0, 16'h0100, 16'h0100);

    // Reset during EXEC of an add: no write, reset outputs next cycle
    regs[1] = 16'd5; regs[2] = 16'd7;
    issue(OP_ADD, 1'b0, 3'd0, 4'd1, 4'd2, 8'd0);
    @(negedge clock);
    check("rexec_in_exec", {31'b0, alu_format}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rexec_rf_we", {31'b0, rf_we}, 32'd0);
    check("rexec_ready", {31'b0, ifc.ready}, 32'd1);
    check("rexec_alu_format", {31'b0, alu_format}, 32'd0);
    check("rexec_alu_a", {16'b0, alu_res}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rexec_rf_we_next", {31'b0, rf_we}, 32'd0);
    check("rexec_pc_load_next", {31'b0, pc_load}, 32'd0);

    // Reset arriving in the WB cycle suppresses the write in that cycle
    issue(OP_ADD, 1'b0, 3'd0, 4'd1, 4'd2, 8'd0);
    @(negedge clock);
    @(negedge clock);
    check("rwb_we_before", {31'b0, rf_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rwb_we_gated", {31'b0, rf_we}, 32'd0);
    @(negedge clock);
    check("rwb_we_after", {31'b0, rf_we}, 32'd0);
    check("rwb_ready_after", {31'b0, ifc.ready}, 32'd1);
    reset = 1'b0;

    // Next accept after reset works; wrap of 0xFFFF + 1
    regs[5] = 16'hFFFF; regs[6] = 16'h0001;
    push_ev(EV_WRITE, 3, 16'h0000, 8'd5);
    issue(OP_ADD, 1'b0, 3'd0, 4'd5, 4'd6, 8'd0);
    observe("add_post_rst", 1'b1, 4'd0, 1'b1, 3'd0, 16'hFFFF, 16'h0001);

    // branch ge inclusive with equal operands: taken
    regs[5] = 16'h8000; regs[6] = 16'h8000;
    push_ev(EV_PCLOAD, 3, 16'h0000, 8'hFF);
    issue(OP_BRANCH, 1'b1, 3'd2, 4'd5, 4'd6, 8'hFF);
    observe("br_ge_eq", 1'b1, 4'd4, 1'b1, 3'd2, 16'h8000, 16'h8000);

`ifdef ALU_SEQ_STATS_EN
    check("stat_retired", {16'b0, stat_retired}, 32'd2);
    check("stat_taken", {16'b0, stat_taken}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
